// File: rtl/conv_bank_scheduler_if.sv
// Handshake bundle between conv_bank_scheduler and its upstream source, kernel bank and downstream sink.
interface conv_bank_scheduler_if #(
  parameter int unsigned NUM_KERNELS   = 4,
  parameter int unsigned WORD_SIZE     = 16,
  parameter int unsigned KERNEL_HEIGHT = 16
);
  localparam int unsigned ID_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;

  logic                                                  start_i;
  logic                                                  busy_o;
  logic                                                  done_o;
  logic                                                  valid_i;
  logic                                                  ready_o;
  logic [WORD_SIZE-1:0]                                  data_i;
  logic [NUM_KERNELS-1:0]                                k_start_o;
  logic [NUM_KERNELS-1:0]                                k_valid_o;
  logic [NUM_KERNELS-1:0]                                k_ready_i;
  logic [WORD_SIZE-1:0]                                  k_data_o;
  logic [NUM_KERNELS-1:0]                                k_valid_i;
  logic [NUM_KERNELS-1:0]                                k_ready_o;
  logic [NUM_KERNELS-1:0][KERNEL_HEIGHT:0][WORD_SIZE-1:0] k_data_i;
  logic                                                  valid_o;
  logic                                                  ready_i;
  logic [KERNEL_HEIGHT:0][WORD_SIZE-1:0]                 data_o;
  logic [ID_W-1:0]                                       kernel_id_o;

  modport slave (
    input  start_i, valid_i, data_i, k_ready_i, k_valid_i, k_data_i, ready_i,
    output busy_o, done_o, ready_o, k_start_o, k_valid_o, k_data_o, k_ready_o,
           valid_o, data_o, kernel_id_o
  );

  modport master (
    output start_i, valid_i, data_i, k_ready_i, k_valid_i, k_data_i, ready_i,
    input  busy_o, done_o, ready_o, k_start_o, k_valid_o, k_data_o, k_ready_o,
           valid_o, data_o, kernel_id_o
  );
endinterface

// File: rtl/conv_bank_scheduler.sv
// Broadcasts each input word to every kernel of a conv bank and round-robin merges
// the kernel output beats onto one registered downstream port, pulsing done_o per frame.
module conv_bank_scheduler #(
  parameter int unsigned NUM_KERNELS        = 4,
  parameter int unsigned WORD_SIZE          = 16,
  parameter int unsigned KERNEL_HEIGHT      = 16,
  parameter int unsigned INPUT_WORDS        = 64,
  parameter int unsigned OUTPUTS_PER_KERNEL = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  conv_bank_scheduler_if.slave bus
);
  localparam int unsigned ID_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
  localparam int unsigned IN_W = $clog2(INPUT_WORDS + 1);
  localparam int unsigned OC_W = $clog2(OUTPUTS_PER_KERNEL + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;
  typedef logic [KERNEL_HEIGHT:0][WORD_SIZE-1:0] beat_t;

  state_e                             state_q, state_d;
  logic                               busy_q, busy_d;
  logic                               done_q, done_d;
  logic [NUM_KERNELS-1:0]             k_start_q, k_start_d;
  logic [NUM_KERNELS-1:0]             taken_q, taken_d;
  logic [IN_W-1:0]                    in_cnt_q, in_cnt_d;
  logic [NUM_KERNELS-1:0][OC_W-1:0]   out_cnt_q, out_cnt_d;
  logic [ID_W-1:0]                    ptr_q, ptr_d;
  logic                               valid_q, valid_d;
  beat_t                              data_q, data_d;
  logic [ID_W-1:0]                    id_q, id_d;

  logic                               run, in_done, ready, load, all_out_done;
  logic [NUM_KERNELS-1:0]             k_valid, k_ready, req;
  logic                               gnt_found;
  logic [ID_W-1:0]                    gnt_idx, cand;
  int unsigned                        idx;

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    k_start_d = '0;
    taken_d   = taken_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    ptr_d     = ptr_q;
    valid_d   = valid_q;
    data_d    = data_q;
    id_d      = id_q;
    idx       = 0;
    cand      = '0;

    run     = (state_q == RUN);
    in_done = (in_cnt_q == IN_W'(INPUT_WORDS));
    ready   = run && !in_done && (&(taken_q | bus.k_ready_i));
    // Already-served kernels drop valid so a stalled word never reaches them twice.
    k_valid = (run && !in_done && bus.valid_i) ? ~taken_q : '0;
    load    = !valid_q || bus.ready_i;

    all_out_done = 1'b1;
    for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
      req[i] = bus.k_valid_i[i] && (state_q != IDLE) &&
               (out_cnt_q[i] != OC_W'(OUTPUTS_PER_KERNEL));
      if (out_cnt_q[i] != OC_W'(OUTPUTS_PER_KERNEL)) all_out_done = 1'b0;
    end

    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned off = 1; off <= NUM_KERNELS; off++) begin
      idx  = (32'(ptr_q) + off) % NUM_KERNELS;
      cand = ID_W'(idx);
      if (!gnt_found && req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
    k_ready = (load && gnt_found) ? (NUM_KERNELS'(1) << gnt_idx) : '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          state_d   = RUN;
          k_start_d = '1;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          taken_d   = '0;
        end
      end
      RUN: begin
        if (bus.valid_i && ready) begin
          taken_d  = '0;
          in_cnt_d = in_cnt_q + IN_W'(1);
          if (in_cnt_q == IN_W'(INPUT_WORDS - 1)) state_d = DRAIN;
        end else begin
          taken_d = taken_q | (k_valid & bus.k_ready_i);
        end
      end
      DRAIN: begin
        if (all_out_done && !valid_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);

    if (load) begin
      if (gnt_found) begin
        valid_d            = 1'b1;
        data_d             = bus.k_data_i[gnt_idx];
        id_d               = gnt_idx;
        ptr_d              = gnt_idx;
        out_cnt_d[gnt_idx] = out_cnt_q[gnt_idx] + OC_W'(1);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      k_start_q <= '0;
      taken_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      ptr_q     <= ID_W'(NUM_KERNELS - 1);
      valid_q   <= 1'b0;
      data_q    <= '0;
      id_q      <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      k_start_q <= k_start_d;
      taken_q   <= taken_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      ptr_q     <= ptr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      id_q      <= id_d;
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.k_start_o   = k_start_q;
  assign bus.ready_o     = ready;
  assign bus.k_valid_o   = k_valid;
  assign bus.k_data_o    = bus.data_i;
  assign bus.k_ready_o   = k_ready;
  assign bus.valid_o     = valid_q;
  assign bus.data_o      = data_q;
  assign bus.kernel_id_o = id_q;
endmodule

// File: tb/tb_conv_bank_scheduler.sv
// Randomized scoreboard bench for conv_bank_scheduler: frame-level model of fork,
// round-robin merge and frame completion, checked every cycle on the falling edge.
module tb_conv_bank_scheduler;
  typedef logic [16:0][15:0] beat_t;
  typedef struct packed { logic [1:0] id; beat_t data; } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_bank_scheduler_if #(.NUM_KERNELS(4), .WORD_SIZE(16), .KERNEL_HEIGHT(16)) bus ();

  conv_bank_scheduler #(
    .NUM_KERNELS(4), .WORD_SIZE(16), .KERNEL_HEIGHT(16),
    .INPUT_WORDS(64), .OUTPUTS_PER_KERNEL(4)
  ) dut (
    .clk_i(clk), .reset_i(rst), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // stimulus state
  logic        rnd = 1'b0, feed = 1'b0, stall_en = 1'b0, bp_hold = 1'b0;
  int          widx = 0, pushed = 0, stall_cnt = 0;
  int          beats_left [4];
  logic [15:0] cur_word = '0;
  logic        up_adv = 1'b0;
  logic [3:0]  kout_adv = '0;

  // reference model state
  int          phase = 0;           // 0 idle, 1 accepting input, 2 draining outputs
  int          acc = 0, last = 3, cyc = 0, acc_first = -1, acc_last = -1;
  int          dlv [4];
  int          sent [4];
  logic [15:0] kq [4][$];
  rec_t        oq [$];
  int          id_log [$];
  logic [3:0]  exp_kstart = '0, exp_kv, exp_gnt;
  logic        exp_done = 1'b0, exp_ready, all_ok, load_m, drain_exit;
  int          g, c, done_seen = 0, kstart_seen = 0;
  rec_t        r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stimulus driver: upstream words, kernel handshakes, downstream ready.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      bus.valid_i = 1'b0; bus.k_valid_i = '0; bus.k_ready_i = '0; bus.ready_i = 1'b0;
      up_adv = 1'b0; kout_adv = '0;
    end else begin
      if (up_adv) widx++;
      up_adv = 1'b0;
      if (feed && widx < 64) begin
        if (pushed == widx) begin
          cur_word = 16'($urandom);
          for (int i = 0; i < 4; i++) kq[i].push_back(cur_word);
          pushed++;
        end
        bus.data_i = cur_word;
        if (stall_en && widx == 5 && stall_cnt < 3) begin
          bus.valid_i = 1'b1; bus.k_ready_i = 4'b1011; stall_cnt++;
        end else begin
          bus.valid_i   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
          bus.k_ready_i = rnd ? (4'($urandom) | 4'($urandom)) : 4'hF;
        end
      end else begin
        bus.valid_i   = 1'b0;
        bus.k_ready_i = rnd ? 4'($urandom) : 4'hF;
      end
      for (int i = 0; i < 4; i++) begin
        if (kout_adv[i]) beats_left[i]--;
        bus.k_valid_i[i] = (beats_left[i] > 0) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
        for (int w = 0; w < 17; w++) bus.k_data_i[i][w] = 16'($urandom);
      end
      kout_adv = '0;
      bus.ready_i = bp_hold ? 1'b0 : (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor and reference model.
  always @(negedge clk) begin
    if (rst) begin
      phase = 0; acc = 0; last = 3; exp_kstart = '0; exp_done = 1'b0;
      oq.delete();
      for (int i = 0; i < 4; i++) begin dlv[i] = 0; sent[i] = 0; kq[i].delete(); end
    end else begin
      cyc++;
      all_ok = 1'b1;
      for (int i = 0; i < 4; i++) if (!(dlv[i] > acc || bus.k_ready_i[i])) all_ok = 1'b0;
      exp_ready = (phase == 1) && (acc < 64) && all_ok;
      for (int i = 0; i < 4; i++)
        exp_kv[i] = bus.valid_i && (phase == 1) && (acc < 64) && !(dlv[i] > acc);
      load_m = (oq.size() == 0) || bus.ready_i;
      g = -1;
      if (load_m && phase != 0)
        for (int off = 1; off <= 4; off++) begin
          c = (last + off) % 4;
          if (g < 0 && bus.k_valid_i[c] && sent[c] < 4) g = c;
        end
      exp_gnt = (g >= 0) ? (4'b0001 << g) : 4'b0000;

      chk("busy_o", 64'(bus.busy_o), 64'(phase != 0));
      chk("done_o", 64'(bus.done_o), 64'(exp_done));
      chk("k_start_o", 64'(bus.k_start_o), 64'(exp_kstart));
      chk("ready_o", 64'(bus.ready_o), 64'(exp_ready));
      chk("k_valid_o", 64'(bus.k_valid_o), 64'(exp_kv));
      chk("k_ready_o", 64'(bus.k_ready_o), 64'(exp_gnt));
      chk("valid_o", 64'(bus.valid_o), 64'(oq.size() != 0));

      drain_exit = (phase == 2) && (oq.size() == 0);
      for (int i = 0; i < 4; i++) if (sent[i] != 4) drain_exit = 1'b0;

      if (bus.valid_o && bus.ready_i) begin
        if (oq.size() == 0) begin
          chk("out_unexpected", 64'(1), 64'(0));
        end else begin
          r = oq.pop_front();
          chk("kernel_id_o", 64'(bus.kernel_id_o), 64'(r.id));
          chk_beat("data_o", bus.data_o, r.data);
          id_log.push_back(int'(r.id));
        end
      end
      for (int i = 0; i < 4; i++)
        if (bus.k_valid_o[i] && bus.k_ready_i[i]) begin
          if (kq[i].size() == 0) chk("k_word_extra", 64'(i + 1), 64'(0));
          else chk("k_data_o", 64'(bus.k_data_o), 64'(kq[i].pop_front()));
          dlv[i]++;
        end
      if (bus.valid_i && bus.ready_o) begin
        acc++;
        if (acc_first < 0) acc_first = cyc;
        acc_last = cyc;
        up_adv = 1'b1;
      end
      if (g >= 0) begin
        oq.push_back({2'(g), bus.k_data_i[g]});
        sent[g]++;
        last = g;
      end
      for (int i = 0; i < 4; i++) if (bus.k_valid_i[i] && bus.k_ready_o[i]) kout_adv[i] = 1'b1;
      if (bus.k_start_o != 4'b0) kstart_seen++;
      if (bus.done_o) done_seen++;

      exp_kstart = (phase == 0 && bus.start_i) ? 4'hF : 4'h0;
      exp_done   = drain_exit;
      if (phase == 0 && bus.start_i) begin
        phase = 1; acc = 0;
        for (int i = 0; i < 4; i++) begin dlv[i] = 0; sent[i] = 0; end
      end else if (phase == 1 && acc == 64) phase = 2;
      else if (drain_exit) phase = 0;
    end
  end

  task automatic start_frame();
    @(posedge clk); #2;
    widx = 0; pushed = 0; stall_cnt = 0; feed = 1'b1;
    done_seen = 0; kstart_seen = 0; acc_first = -1; acc_last = -1;
    id_log.delete();
    for (int i = 0; i < 4; i++) begin kq[i].delete(); beats_left[i] = 4; end
    bus.start_i = 1'b1;
    @(posedge clk); #2;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.done_o && n < max_cyc);
    chk("done_timeout", 64'(n < max_cyc), 64'(1));
    @(negedge clk);
    chk("done_pulses", 64'(done_seen), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("words_per_kernel", 64'(dlv[i]), 64'(64));
      chk("beats_per_kernel", 64'(sent[i]), 64'(4));
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 64'(bus.busy_o), 64'(0));
    chk("rst_done", 64'(bus.done_o), 64'(0));
    chk("rst_valid_o", 64'(bus.valid_o), 64'(0));
    chk("rst_ready_o", 64'(bus.ready_o), 64'(0));
    chk("rst_k_valid_o", 64'(bus.k_valid_o), 64'(0));
    chk("rst_k_ready_o", 64'(bus.k_ready_o), 64'(0));
    chk("rst_k_start_o", 64'(bus.k_start_o), 64'(0));
    chk("rst_kernel_id", 64'(bus.kernel_id_o), 64'(0));
    chk_beat("rst_data_o", bus.data_o, '0);
  endtask

  initial begin
    int n;
    bus.start_i = 1'b0; bus.valid_i = 1'b0; bus.data_i = '0; bus.k_ready_i = '0;
    bus.k_valid_i = '0; bus.k_data_i = '0; bus.ready_i = 1'b0;
    for (int i = 0; i < 4; i++) beats_left[i] = 0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk); #2 rst = 1'b0;

    // Frame 1: everything ready, full-rate input, all kernels requesting.
    start_frame();
    wait_done(600);
    chk("input_span_cycles", 64'(acc_last - acc_first), 64'(63));
    chk("k_start_pulses", 64'(kstart_seen), 64'(1));
    for (int i = 0; i < 8; i++) chk("rr_order", 64'(id_log[i]), 64'(i % 4));

    // Frame 2: random traffic, fork stall on word 5, downstream backpressure.
    rnd = 1'b1; stall_en = 1'b1; bp_hold = 1'b1;
    start_frame();
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.valid_o && n < 100);
    chk("bp_valid_seen", 64'(bus.valid_o), 64'(1));
    repeat (5) begin
      @(negedge clk);
      chk("bp_k_ready_o", 64'(bus.k_ready_o), 64'(0));
      if (oq.size() == 0) chk("bp_expected_beat", 64'(0), 64'(1));
      else begin
        chk_beat("bp_data_o", bus.data_o, oq[0].data);
        chk("bp_kernel_id", 64'(bus.kernel_id_o), 64'(oq[0].id));
      end
    end
    bp_hold = 1'b0;
    wait_done(4000);

    // Frame 3: reset after 20 words; partial frame must vanish with no done_o.
    stall_en = 1'b0;
    start_frame();
    n = 0;
    while (acc < 20 && n < 1000) begin @(negedge clk); n++; end
    chk("reach_20_words", 64'(acc >= 20), 64'(1));
    @(posedge clk); #2;
    rst = 1'b1; feed = 1'b0;
    for (int i = 0; i < 4; i++) beats_left[i] = 0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    done_seen = 0;
    repeat (20) @(negedge clk);
    chk("no_done_after_abort", 64'(done_seen), 64'(0));

    // Frame 4: clean random frame after the abort.
    start_frame();
    wait_done(4000);
    chk("k_start_pulses_f4", 64'(kstart_seen), 64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
